mem_stage: RTL

Parametrised memory-access pipeline stage for the JARVIS core, sitting between execute and writeback. Holds a byte-addressable data memory with sub-word loads/stores (byte/half/word, and double when XLEN=64), sign/zero extension, byte-enable writes, and a valid/stall/flush pipeline handshake. All outputs are registered; one-cycle stage latency.

---
 rtl/mem_stage_if.sv | 47 ++++
 rtl/mem_stage.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// mem_stage_if: groups the execute-side request and writeback-side result
// signals of the memory-access stage. The driver side (execute stage or a
// bench) uses the master modport; the stage itself uses the slave modport.
interface mem_stage_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  // Request from execute
  logic                  valid_in;
  logic                  stall_in;
  logic                  flush_in;
  logic [XLEN-1:0]       next_pc_in;
  logic                  rd_write_enable_in;
  logic [REG_ADDR_W-1:0] rd_write_addr_in;
  logic                  res_src_in;
  logic [XLEN-1:0]       exec_data_in;
  logic                  mem_read_enable;
  logic                  mem_write_enable;
  logic [2:0]            mem_funct3;
  logic [XLEN-1:0]       mem_write_data;

  // Registered result towards writeback
  logic                  valid_out;
  logic [XLEN-1:0]       exec_data_out;
  logic [XLEN-1:0]       mem_data_out;
  logic [XLEN-1:0]       next_pc_out;
  logic                  rd_write_enable_out;
  logic [REG_ADDR_W-1:0] rd_write_addr_out;
  logic                  res_src_out;
  logic                  misalign_out;

  modport master (
    output valid_in, stall_in, flush_in, next_pc_in, rd_write_enable_in,
           rd_write_addr_in, res_src_in, exec_data_in, mem_read_enable,
           mem_write_enable, mem_funct3, mem_write_data,
    input  valid_out, exec_data_out, mem_data_out, next_pc_out,
           rd_write_enable_out, rd_write_addr_out, res_src_out, misalign_out
  );

  modport slave (
    input  valid_in, stall_in, flush_in, next_pc_in, rd_write_enable_in,
           rd_write_addr_in, res_src_in, exec_data_in, mem_read_enable,
           mem_write_enable, mem_funct3, mem_write_data,
    output valid_out, exec_data_out, mem_data_out, next_pc_out,
           rd_write_enable_out, rd_write_addr_out, res_src_out, misalign_out
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and writeback.
// Byte-addressable data memory with B/H/W(/D) loads and stores, sign/zero
// extension, byte-enable writes and a valid/stall/flush handshake. All
// outputs are registered (one-cycle latency).
// Optional feature macro: MEM_STAGE_MISALIGN_TRAP_EN
//   defined   - misaligned H/W/D accesses are trapped (store suppressed,
//               misalign_out=1, rd_write_enable_out=0, mem_data_out=0)
//   undefined - the offset is aligned down to the access size and
//               misalign_out stays 0
module mem_stage #(
  parameter int XLEN       = 32,
  parameter int MEM_WORDS  = 1024,
  parameter int REG_ADDR_W = 5
) (
  input logic       clk,
  input logic       rst_n,
  mem_stage_if.slave bus
);

  localparam int NB = XLEN / 8;           // bytes per word
  localparam int OB = $clog2(NB);         // byte-offset bits
  localparam int WI = $clog2(MEM_WORDS);  // word-index bits

  logic [XLEN-1:0] mem [MEM_WORDS];

  logic [OB-1:0]   offset;
  logic [OB-1:0]   eff_offset;
  logic [OB-1:0]   align_mask;
  logic [WI-1:0]   word_idx;
  logic [1:0]      size;
  logic            legal;
  logic            trap;
  logic            sign_bit;
  logic            wen;
  logic [XLEN-1:0] rd_word;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] size_mask;
  logic [XLEN-1:0] load_ext;
  logic [XLEN-1:0] load_result;
  logic [XLEN-1:0] wdata;
  logic [NB-1:0]   be_base;
  logic [NB-1:0]   be;

  // Upper address bits are dropped, so accesses wrap over the array.
  assign offset   = bus.exec_data_in[OB-1:0];
  assign word_idx = bus.exec_data_in[OB +: WI];
  assign size     = bus.mem_funct3[1:0];

  // Decode access size, legality and alignment handling.
  // NOTE: every variable of an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    legal      = 1'b1;
    align_mask = '0;
    if (bus.mem_funct3 == 3'b111) legal = 1'b0;
    if (XLEN == 32 && (bus.mem_funct3 == 3'b011 || bus.mem_funct3 == 3'b110))
      legal = 1'b0;
    case (size)
      2'd0:    align_mask = '0;
      2'd1:    align_mask = OB'(1);
      2'd2:    align_mask = OB'(3);
      default: align_mask = OB'(7);
    endcase
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    trap       = bus.valid_in && (bus.mem_read_enable || bus.mem_write_enable)
                 && legal && (|(offset & align_mask));
    eff_offset = offset;
`else
    trap       = 1'b0;
    eff_offset = offset & ~align_mask;
`endif
  end

  // Load path: read the word, shift the addressed bytes down, then extend.
  always_comb begin
    rd_word   = mem[word_idx];
    shifted   = rd_word >> {eff_offset, 3'b000};
    size_mask = '0;
    sign_bit  = 1'b0;
    case (size)
      2'd0:    begin size_mask[7:0]  = '1; sign_bit = shifted[7];      end
      2'd1:    begin size_mask[15:0] = '1; sign_bit = shifted[15];     end
      2'd2:    begin size_mask[31:0] = '1; sign_bit = shifted[31];     end
      default: begin size_mask       = '1; sign_bit = shifted[XLEN-1]; end
    endcase
    load_ext = shifted & size_mask;
    if (!bus.mem_funct3[2] && sign_bit) load_ext = load_ext | ~size_mask;
    load_result = (legal && !trap) ? load_ext : '0;
  end

  // Store path: lane-align data and byte enables; gate the write.
  always_comb begin
    be_base = '0;
    case (size)
      2'd0:    be_base[0]   = 1'b1;
      2'd1:    be_base[1:0] = '1;
      2'd2:    be_base[3:0] = '1;
      default: be_base      = '1;
    endcase
    be    = be_base << eff_offset;
    wdata = bus.mem_write_data << {eff_offset, 3'b000};
    wen   = bus.valid_in && bus.mem_write_enable && !bus.stall_in &&
            !bus.flush_in && legal && !trap;
  end

  // Byte-enable write into the data memory; a store seen during reset is dropped.
  // NOTE: the array has no reset branch; clearing a RAM would need a per-word
  // loop and prevents mapping onto a memory macro.
  always_ff @(posedge clk) begin
    if (wen && rst_n) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[word_idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Stage output register: flush kills, stall holds, otherwise capture.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.valid_out           <= 1'b0;
      bus.exec_data_out       <= '0;
      bus.mem_data_out        <= '0;
      bus.next_pc_out         <= '0;
      bus.rd_write_enable_out <= 1'b0;
      bus.rd_write_addr_out   <= '0;
      bus.res_src_out         <= 1'b0;
      bus.misalign_out        <= 1'b0;
    end else if (bus.flush_in) begin
      bus.valid_out           <= 1'b0;
      bus.rd_write_enable_out <= 1'b0;
      bus.misalign_out        <= 1'b0;
    end else if (!bus.stall_in) begin
      bus.valid_out           <= bus.valid_in;
      bus.exec_data_out       <= bus.exec_data_in;
      bus.mem_data_out        <= load_result;
      bus.next_pc_out         <= bus.next_pc_in;
      bus.rd_write_enable_out <= bus.valid_in && bus.rd_write_enable_in && !trap;
      bus.rd_write_addr_out   <= bus.rd_write_addr_in;
      bus.res_src_out         <= bus.res_src_in;
      bus.misalign_out        <= trap;
    end
  end

endmodule
